button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end input stage that cleans a raw mechanical push-button or switch input before it reaches the team's registered logic, e.g. the D input or clock-enable of a flip-flop.
- Synchronises the asynchronous pin into the clk domain and rejects contact bounce with a counter-qualified state machine.
- Produces a clean level plus single-cycle rise and fall strobes.

Parameters:
- SYNC_STAGES, 2: depth of the synchroniser flop chain; must be >= 2.
- DEBOUNCE_CYCLES, 1000000: consecutive clk edges the synchronised input must hold a new value before it is accepted; 10 ms at 100 MHz; must be >= 2.
- CNT_W, derived as a localparam ($clog2(DEBOUNCE_CYCLES)); not overridable.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  1  raw asynchronous pin, may bounce.
- btn_level  output  1  debounced, synchronised level.
- btn_rise  output  1  one-cycle strobe when btn_level goes 0->1.
- btn_fall  output  1  one-cycle strobe when btn_level goes 1->0.

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clk.
- Reset values: all synchroniser flops, counter, btn_level, btn_rise and btn_fall are 0; FSM is in IDLE_LOW. Reset overrides every other event on the same edge.
- Synchroniser: sync[0] <= btn_in, sync[i] <= sync[i-1]. The FSM sees only s = sync[SYNC_STAGES-1].
- FSM states: IDLE_LOW (level 0), ARM_HIGH (level 0, counting), HOLD_HIGH (level 1), ARM_LOW (level 1, counting).
  - IDLE_LOW: s=1 -> ARM_HIGH with cnt=1. Otherwise stay, cnt=0.
  - ARM_HIGH with s=1: if cnt==DEBOUNCE_CYCLES-1 -> HOLD_HIGH, btn_level<=1, btn_rise<=1, cnt<=0. Otherwise cnt++.
  - ARM_HIGH with s=0: -> IDLE_LOW, cnt=0, no strobe.
  - HOLD_HIGH and ARM_LOW: mirror images with s inverted and btn_fall in place of btn_rise.
- Exact latency: btn_in is first sampled at edge 1 with its new value and held stable. btn_level changes after edge SYNC_STAGES+DEBOUNCE_CYCLES. Strobes assert in the same cycle btn_level changes and last exactly one cycle.
- Glitch rule: a value seen at s for DEBOUNCE_CYCLES-1 or fewer consecutive edges is discarded. The counter restarts from zero on any reversion; there is no accumulation across bounces.
- Strobe exclusivity: btn_rise and btn_fall are never both 1. No strobe ever asserts without a btn_level change.
- Counter saturation: the counter never wraps; it is cleared on every state change.
- Reset mid-count: all progress is lost. After reset deasserts, a pin already held high is treated as a new press: full latency, then btn_rise fires.
- Input already high during reset: btn_level stays 0 through reset. The normal rise with strobe follows release.

Decomposition:
- Shared include debounce_defs.vh holds:
  - FSM state encodings: 2-bit localparams IDLE_LOW=0, ARM_HIGH=1, HOLD_HIGH=2, ARM_LOW=3.
  - Default debounce constant DEBOUNCE_10MS_100MHZ.
- One sub-module: sync_chain, parameter STAGES, ports clk, reset, d, q. It is reusable for other async inputs in the design.
- The FSM and counter live in button_conditioner.

Test Plan (simulation overrides: DEBOUNCE_CYCLES=8, SYNC_STAGES=2; latency 10 edges):
- Clean press: btn_in 0->1, held 20 cycles -> btn_level rises after edge 10. btn_rise=1 for exactly that cycle. btn_fall stays 0.
- Boundary glitches: high pulse of 7 sampled edges -> no change and no strobe. High pulse of exactly 8 edges -> btn_level=1 after edge 10 with a single btn_rise, then 0 after edge 18 with a single btn_fall.
- Bounce: btn_in toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one btn_rise, 10 edges after the final stable sample. btn_level never toggles during the bounce.
- Release: from HOLD_HIGH, btn_in 1->0 with three 2-cycle bounces, then held 0 -> one btn_fall, 10 edges after the last stable transition. No btn_rise.
- Reset mid-arm: reset asserted for 1 cycle while in ARM_HIGH (cnt=5), btn_in held 1 -> outputs 0 during reset. btn_rise fires exactly 10 edges after reset deasserts, not earlier.
- Reset with input high: btn_in=1 throughout a 5-cycle reset -> btn_level=0 during reset. btn_rise fires 10 edges after release. The strobe-exclusivity assertion holds for the whole run.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared debounce FSM encodings and default timing constant
package button_conditioner_pkg;
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    ARM_HIGH  = 2'd1,
    HOLD_HIGH = 2'd2,
    ARM_LOW   = 2'd3
  } state_t;
  localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;
endpackage

// File: rtl/button_conditioner_sync_chain.sv
// sync_chain: reusable multi-flop synchroniser for asynchronous single-bit inputs
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync;
  always_ff @(posedge clk)
    sync <= reset ? '0 : {sync[STAGES-2:0], d};
  assign q = sync[STAGES-1];
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces a raw button into a level plus rise/fall strobes
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic s, done, rise_d, fall_d;
  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(btn_in),
    .q(s)
  );
  assign done = cnt == CNT_LAST;
  always_comb begin
    state_d = state;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state)
      IDLE_LOW: if (s) begin
        state_d = ARM_HIGH;
        cnt_d   = CNT_W'(1);
      end
      ARM_HIGH: if (!s) state_d = IDLE_LOW;
        else if (done) begin
          state_d = HOLD_HIGH;
          rise_d  = 1'b1;
        end else cnt_d = cnt + 1'b1;
      HOLD_HIGH: if (!s) begin
        state_d = ARM_LOW;
        cnt_d   = CNT_W'(1);
      end
      ARM_LOW: if (s) state_d = HOLD_HIGH;
        else if (done) begin
          state_d = IDLE_LOW;
          fall_d  = 1'b1;
        end else cnt_d = cnt + 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    state    <= reset ? IDLE_LOW : state_d;
    cnt      <= reset ? '0 : cnt_d;
    btn_rise <= reset ? 1'b0 : rise_d;
    btn_fall <= reset ? 1'b0 : fall_d;
  end
  assign btn_level = (state == HOLD_HIGH) || (state == ARM_LOW);
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked against a run-length debounce model
module tb_button_conditioner;
  localparam int SYNC = 2;
  localparam int DEB  = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_in = 1'b0;
  logic btn_level, btn_rise, btn_fall;
  int checks = 0;
  int errors = 0;
  logic hq[$];
  logic m_level = 1'b0;
  logic m_rise = 1'b0;
  logic m_fall = 1'b0;
  int run = 0;
  logic rb;
  int len;

  button_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Level flips once the delayed pin has disagreed with it for DEB consecutive edges.
  task automatic model(input logic b, input logic r);
    logic s;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      hq.delete();
      repeat (SYNC) hq.push_back(1'b0);
      run = 0;
      m_level = 1'b0;
    end else begin
      s = hq.pop_front();
      hq.push_back(b);
      run = (s != m_level) ? run + 1 : 0;
      if (run == DEB) begin
        m_level = s;
        m_rise = s;
        m_fall = !s;
        run = 0;
      end
    end
  endtask

  task automatic step(input logic b, input logic r);
    btn_in = b;
    reset = r;
    @(posedge clk);
    model(b, r);
    #1;
    chk("level", btn_level, m_level);
    chk("rise", btn_rise, m_rise);
    chk("fall", btn_fall, m_fall);
    chk("exclusive", btn_rise & btn_fall, 1'b0);
  endtask

  task automatic seg(input logic b, input int n_on, input int n, input int ra, input int fa);
    for (int i = 1; i <= n; i++) begin
      step(i <= n_on ? b : !b, 1'b0);
      chk("seg_rise", btn_rise, i == ra);
      chk("seg_fall", btn_fall, i == fa);
    end
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b1);
    chk("rst_level", btn_level, 1'b0);
    chk("rst_rise", btn_rise, 1'b0);
    chk("rst_fall", btn_fall, 1'b0);
    seg(1'b1, 20, 20, 10, 0);
    seg(1'b0, 20, 20, 0, 10);
    seg(1'b1, 7, 25, 0, 0);
    seg(1'b1, 8, 25, 10, 18);
    for (int i = 0; i < 30; i++) begin
      step(((i / 3) % 2) == 0, 1'b0);
      chk("bounce_level", btn_level, 1'b0);
    end
    seg(1'b1, 20, 20, 10, 0);
    for (int i = 0; i < 12; i++) begin
      step(((i / 2) % 2) == 1, 1'b0);
      chk("release_level", btn_level, 1'b1);
    end
    seg(1'b0, 20, 20, 0, 10);
    repeat (7) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("midarm_level", btn_level, 1'b0);
    chk("midarm_rise", btn_rise, 1'b0);
    seg(1'b1, 20, 20, 10, 0);
    seg(1'b0, 20, 20, 0, 10);
    repeat (5) begin
      step(1'b1, 1'b1);
      chk("rsthigh_level", btn_level, 1'b0);
    end
    seg(1'b1, 20, 20, 10, 0);
    for (int k = 0; k < 80; k++) begin
      rb = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) step(rb, $urandom_range(0, 49) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
